// File: rtl/nn_smoothgrad_train_sched.sv
// nn_smoothgrad_train_sched: sequences load/accumulate/commit windows with per-epoch resistance decay
module nn_smoothgrad_train_sched #(
  parameter int N_RESISTANCE = 9,
  parameter int N_WIN        = 10,
  parameter int N_EPOCH      = 16
) (
  input  logic                    CLK,
  input  logic                    INIT_N,
  input  logic                    START,
  input  logic                    ABORT,
  input  logic [N_WIN-1:0]        WINDOW_LEN,
  input  logic [N_EPOCH-1:0]      EPOCHS,
  input  logic [N_RESISTANCE-1:0] RES_START,
  input  logic [N_RESISTANCE-1:0] RES_MIN,
  input  logic [N_RESISTANCE-1:0] RES_STEP,
  output logic                    ACC_INIT,
  output logic                    ACC_EN,
  output logic                    CLK_TRAINING_flag,
  output logic [N_RESISTANCE-1:0] RESISTANCE,
  output logic                    COMMIT,
  output logic [N_EPOCH-1:0]      EPOCH_CNT,
  output logic                    BUSY,
  output logic                    DONE
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_COMMIT, S_FIN} state_t;
  state_t state_q, state_d;
  logic [N_WIN-1:0] win_q, win_d, wlen_q, wlen_d;
  logic [N_EPOCH-1:0] epochs_q, epochs_d, epoch_q, epoch_d;
  logic [N_RESISTANCE-1:0] res_min_q, res_min_d, res_step_q, res_step_d, res_q, res_d, res_dec;
  logic acc_init_q, acc_en_q, commit_q, done_q, busy_q, win_last;
  always_comb begin
    win_last = win_q == wlen_q - N_WIN'(1);
    res_dec = (res_step_q > res_q || res_q - res_step_q < res_min_q) ? res_min_q : res_q - res_step_q;
    state_d = state_q;
    win_d = win_q;
    wlen_d = wlen_q;
    epochs_d = epochs_q;
    epoch_d = epoch_q;
    res_min_d = res_min_q;
    res_step_d = res_step_q;
    res_d = res_q;
    if (ABORT && state_q != S_IDLE) begin
      state_d = S_IDLE;
      win_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (START && !ABORT) begin
          state_d = S_LOAD;
          wlen_d = (WINDOW_LEN == '0) ? N_WIN'(1) : WINDOW_LEN;
          epochs_d = EPOCHS;
          res_min_d = RES_MIN;
          res_step_d = RES_STEP;
          res_d = RES_START;
          epoch_d = '0;
          win_d = '0;
        end
        S_LOAD: state_d = (epochs_q != '0) ? S_RUN : S_FIN;
        S_RUN: begin
          win_d = win_last ? '0 : win_q + N_WIN'(1);
          if (win_last) begin
            state_d = S_COMMIT;
            epoch_d = epoch_q + N_EPOCH'(1);
            res_d = res_dec;
          end
        end
        S_COMMIT: state_d = (epoch_q == epochs_q) ? S_FIN : S_RUN;
        S_FIN: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end
  // outputs are registered from the next state so they align with the state they describe
  always_ff @(posedge CLK or negedge INIT_N) begin
    if (!INIT_N) begin
      state_q <= S_IDLE;
      win_q <= '0;
      wlen_q <= '0;
      epochs_q <= '0;
      epoch_q <= '0;
      res_min_q <= '0;
      res_step_q <= '0;
      res_q <= '0;
      acc_init_q <= 1'b0;
      acc_en_q <= 1'b0;
      commit_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      wlen_q <= wlen_d;
      epochs_q <= epochs_d;
      epoch_q <= epoch_d;
      res_min_q <= res_min_d;
      res_step_q <= res_step_d;
      res_q <= res_d;
      acc_init_q <= state_d == S_LOAD;
      acc_en_q <= state_d == S_RUN;
      commit_q <= state_d == S_COMMIT;
      done_q <= state_d == S_FIN;
      busy_q <= state_d != S_IDLE;
    end
  end
  assign ACC_INIT = acc_init_q;
  assign ACC_EN = acc_en_q;
  assign CLK_TRAINING_flag = acc_en_q;
  assign COMMIT = commit_q;
  assign DONE = done_q;
  assign BUSY = busy_q;
  assign RESISTANCE = res_q;
  assign EPOCH_CNT = epoch_q;
endmodule

// File: tb/tb_nn_smoothgrad_train_sched.sv
// tb_nn_smoothgrad_train_sched: directed checks of the training scheduler
module tb_nn_smoothgrad_train_sched;
  logic CLK = 1'b0, INIT_N = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic [9:0] WINDOW_LEN = '0;
  logic [15:0] EPOCHS = '0;
  logic [8:0] RES_START = '0, RES_MIN = '0, RES_STEP = '0;
  logic ACC_INIT, ACC_EN, CLK_TRAINING_flag, COMMIT, BUSY, DONE;
  logic [8:0] RESISTANCE;
  logic [15:0] EPOCH_CNT;
  int n_chk = 0, n_fail = 0, ncom = 0;
  int res_log [0:15];
  int cyc, ens, inits;

  nn_smoothgrad_train_sched dut (
    .CLK(CLK), .INIT_N(INIT_N), .START(START), .ABORT(ABORT),
    .WINDOW_LEN(WINDOW_LEN), .EPOCHS(EPOCHS), .RES_START(RES_START),
    .RES_MIN(RES_MIN), .RES_STEP(RES_STEP), .ACC_INIT(ACC_INIT),
    .ACC_EN(ACC_EN), .CLK_TRAINING_flag(CLK_TRAINING_flag),
    .RESISTANCE(RESISTANCE), .COMMIT(COMMIT), .EPOCH_CNT(EPOCH_CNT),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic start_run(input int wl, input int ep, input int rs, input int rm, input int st);
    WINDOW_LEN = 10'(wl);
    EPOCHS = 16'(ep);
    RES_START = 9'(rs);
    RES_MIN = 9'(rm);
    RES_STEP = 9'(st);
    START = 1'b1;
    tick;
    START = 1'b0;
  endtask

  task automatic run_to_done(output int c, output int e, output int i);
    c = 1;
    e = 0;
    i = 0;
    ncom = 0;
    while (!DONE && c < 2000) begin
      if (ACC_INIT) i++;
      if (ACC_EN) e++;
      if (ACC_EN != CLK_TRAINING_flag) chk("flag_eq_en", int'(CLK_TRAINING_flag), int'(ACC_EN));
      if (COMMIT && ncom < 16) begin
        res_log[ncom] = int'(RESISTANCE);
        ncom++;
      end
      tick;
      c++;
    end
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_res", int'(RESISTANCE), 0);
    chk("rst_epoch", int'(EPOCH_CNT), 0);
    chk("rst_init", int'(ACC_INIT), 0);
    chk("rst_done", int'(DONE), 0);
    #10 INIT_N = 1'b1;
    tick;

    start_run(4, 2, 100, 10, 30);
    chk("t1_load_init", int'(ACC_INIT), 1);
    chk("t1_load_res", int'(RESISTANCE), 100);
    chk("t1_load_busy", int'(BUSY), 1);
    run_to_done(cyc, ens, inits);
    chk("t1_cycles", cyc, 12);
    chk("t1_en_cycles", ens, 8);
    chk("t1_inits", inits, 1);
    chk("t1_commits", ncom, 2);
    chk("t1_res0", res_log[0], 70);
    chk("t1_res1", res_log[1], 40);
    chk("t1_epoch", int'(EPOCH_CNT), 2);
    tick;
    chk("t1_idle_busy", int'(BUSY), 0);
    chk("t1_done_pulse", int'(DONE), 0);
    chk("t1_res_hold", int'(RESISTANCE), 40);

    start_run(1, 3, 50, 20, 40);
    chk("t2_load_res", int'(RESISTANCE), 50);
    chk("t2_load_epoch", int'(EPOCH_CNT), 0);
    run_to_done(cyc, ens, inits);
    chk("t2_cycles", cyc, 8);
    chk("t2_commits", ncom, 3);
    chk("t2_res0", res_log[0], 20);
    chk("t2_res1", res_log[1], 20);
    chk("t2_res2", res_log[2], 20);
    tick;

    start_run(5, 0, 30, 1, 1);
    chk("t3_init", int'(ACC_INIT), 1);
    run_to_done(cyc, ens, inits);
    chk("t3_cycles", cyc, 2);
    chk("t3_en", ens, 0);
    chk("t3_commits", ncom, 0);
    chk("t3_epoch", int'(EPOCH_CNT), 0);
    tick;

    start_run(0, 1, 30, 1, 1);
    run_to_done(cyc, ens, inits);
    chk("t4_cycles", cyc, 4);
    chk("t4_en", ens, 1);
    chk("t4_commits", ncom, 1);
    chk("t4_res", res_log[0], 29);
    tick;

    START = 1'b1;
    ABORT = 1'b1;
    tick;
    START = 1'b0;
    ABORT = 1'b0;
    chk("start_abort_idle", int'(BUSY), 0);

    start_run(8, 5, 200, 0, 10);
    WINDOW_LEN = 10'd2;
    EPOCHS = 16'd1;
    RES_STEP = 9'd100;
    START = 1'b1;
    tick;
    START = 1'b0;
    ens = 0;
    for (int c = 2; c <= 12; c++) begin
      if (ACC_EN) ens++;
      tick;
    end
    chk("t5_en_before_abort", ens, 10);
    chk("t5_run_c13", int'(ACC_EN), 1);
    chk("t5_epoch_c13", int'(EPOCH_CNT), 1);
    chk("t5_res_c13", int'(RESISTANCE), 190);
    ABORT = 1'b1;
    tick;
    ABORT = 1'b0;
    chk("t5_abort_busy", int'(BUSY), 0);
    chk("t5_abort_en", int'(ACC_EN), 0);
    chk("t5_abort_flag", int'(CLK_TRAINING_flag), 0);
    chk("t5_abort_done", int'(DONE), 0);
    chk("t5_abort_epoch", int'(EPOCH_CNT), 1);
    chk("t5_abort_res", int'(RESISTANCE), 190);
    ens = 0;
    for (int c = 0; c < 5; c++) begin
      if (DONE || BUSY) ens++;
      tick;
    end
    chk("t5_stays_idle", ens, 0);

    start_run(4, 2, 100, 10, 30);
    tick;
    tick;
    chk("t6_in_run", int'(ACC_EN), 1);
    #2 INIT_N = 1'b0;
    #1;
    chk("t6_rst_busy", int'(BUSY), 0);
    chk("t6_rst_en", int'(ACC_EN), 0);
    chk("t6_rst_res", int'(RESISTANCE), 0);
    chk("t6_rst_epoch", int'(EPOCH_CNT), 0);
    #1 INIT_N = 1'b1;
    tick;
    start_run(4, 2, 100, 10, 30);
    chk("t6_load_init", int'(ACC_INIT), 1);
    run_to_done(cyc, ens, inits);
    chk("t6_cycles", cyc, 12);
    chk("t6_epoch", int'(EPOCH_CNT), 2);
    chk("t6_res_final", int'(RESISTANCE), 40);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/nn_smoothgrad_train_sched.md
Name: nn_smoothgrad_train_sched

Overview:
Training-phase scheduler for a bank of sign-magnitude stochastic gradient accumulators in the stochastic NN fabric. It loads initial weights and sequences fixed-length accumulation windows (epochs). It also drives the shared resistance value with a per-epoch linear decay and emits a commit strobe after each window so downstream logic can sample the accumulated weights. One instance serves an entire layer's accumulators; all outputs are broadcast.

Parameters:
N_RESISTANCE, 9, width of resistance bus and schedule configuration
N_WIN, 10, width of window-length counter (stochastic cycles per epoch)
N_EPOCH, 16, width of epoch counter

Ports:
CLK  input  1  system clock
INIT_N  input  1  asynchronous active-low reset
START  input  1  single-cycle start request; accepted only in IDLE
ABORT  input  1  synchronous abort; returns the FSM to IDLE
WINDOW_LEN  input  N_WIN  cycles per accumulation window; 0 is treated as 1
EPOCHS  input  N_EPOCH  number of windows to run
RES_START  input  N_RESISTANCE  initial resistance
RES_MIN  input  N_RESISTANCE  resistance floor
RES_STEP  input  N_RESISTANCE  per-epoch resistance decrement
ACC_INIT  output  1  load pulse to the accumulators (active high, one cycle)
ACC_EN  output  1  accumulator enable during the window
CLK_TRAINING_flag  output  1  training-window flag; equals ACC_EN
RESISTANCE  output  N_RESISTANCE  current resistance, broadcast to the accumulators
COMMIT  output  1  one-cycle strobe after each completed window
EPOCH_CNT  output  N_EPOCH  number of completed epochs
BUSY  output  1  high in any state except IDLE
DONE  output  1  one-cycle pulse when the run completes normally

Behaviour:
- Reset (INIT_N=0, asynchronous): state=IDLE; RESISTANCE=0; EPOCH_CNT=0; all 1-bit outputs 0; window counter=0; latched configuration=0.
- Outputs are registered, and states are IDLE, LOAD, RUN, COMMIT, FIN.
- IDLE: on START=1, latch WINDOW_LEN (0 becomes 1), EPOCHS, RES_MIN and RES_STEP. Next cycle: RESISTANCE=RES_START, EPOCH_CNT=0, go to LOAD. RES_START is taken directly and is not clamped to RES_MIN.
- LOAD: ACC_INIT=1 for exactly one cycle. Next state is RUN if latched EPOCHS!=0, otherwise FIN.
- RUN: ACC_EN=CLK_TRAINING_flag=1 for exactly latched WINDOW_LEN consecutive cycles. The window counter runs from 0 to WINDOW_LEN-1; on its last cycle it clears and the FSM goes to COMMIT.
- COMMIT: one cycle, with COMMIT=1 and ACC_EN=0.
  - EPOCH_CNT increments by 1.
  - RESISTANCE updates to max(RESISTANCE-RES_STEP, RES_MIN). The subtraction must not wrap: if RES_STEP>RESISTANCE, the result is RES_MIN.
  - Next state is FIN if the incremented EPOCH_CNT equals latched EPOCHS, otherwise RUN. Returning to RUN does not reload, so the accumulators keep their values.
- FIN: DONE=1 for one cycle, then IDLE. RESISTANCE and EPOCH_CNT hold their final values until the next START.
- Per-epoch timing: each epoch occupies WINDOW_LEN+1 cycles. A full run takes 1 (LOAD) + EPOCHS*(WINDOW_LEN+1) + 1 (FIN) cycles after the START-accept cycle.
- ABORT=1 in any non-IDLE state:
  - Next cycle is IDLE with ACC_INIT, ACC_EN, CLK_TRAINING_flag, COMMIT and DONE all 0.
  - EPOCH_CNT and RESISTANCE hold; DONE is not asserted.
  - ABORT has priority over all transitions, including the COMMIT update, which is suppressed.
  - ABORT in IDLE is ignored. START and ABORT together in IDLE: ABORT wins and START is dropped.
- START while BUSY is ignored and does not re-latch configuration.
- Configuration inputs may change freely while BUSY; only the latched copies are used.
- EPOCH_CNT at all-ones does not wrap: EPOCHS is at most 2^N_EPOCH-1, so FIN is always reached first.
- Reset asserted mid-run returns everything to the reset values immediately (asynchronously).

Test Plan:
- Reset then START with WINDOW_LEN=4, EPOCHS=2, RES_START=100, RES_STEP=30, RES_MIN=10 -> one ACC_INIT pulse, then ACC_EN high 4 cycles, COMMIT (RESISTANCE=70), ACC_EN high 4 cycles, COMMIT (RESISTANCE=40), DONE; EPOCH_CNT=2; 12 cycles from accept to the DONE cycle inclusive.
- RES_START=50, RES_STEP=40, RES_MIN=20, EPOCHS=3, WINDOW_LEN=1 -> RESISTANCE sequence 50, 20, 20, 20; no wrap below RES_MIN.
- EPOCHS=0 -> ACC_INIT pulse, then DONE the next cycle; ACC_EN and COMMIT never assert; EPOCH_CNT=0.
- WINDOW_LEN=0, EPOCHS=1 -> ACC_EN high exactly 1 cycle, then COMMIT, then DONE.
- ABORT on the 3rd RUN cycle of epoch 2 (WINDOW_LEN=8) -> IDLE next cycle, EPOCH_CNT=1 held, no DONE. A START pulsed during the run beforehand must not restart it or re-latch configuration.
- INIT_N pulsed low during RUN, asynchronous to CLK -> all outputs 0 and BUSY=0 immediately; a subsequent START runs normally from LOAD.
